// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage and its BTB
package fetch_pkg;
  localparam logic [63:0] NOP_INSTR = 64'h0000_0000_0000_0013;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] instr;
    logic        pred;
  } fetch_entry_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] tag;
    logic [63:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? (c == 2'b11 ? c : c + 2'd1) : (c == 2'b00 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/fetch_btb.sv
// fetch_btb: direct-mapped branch target buffer with 2-bit counters, combinational lookup
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] lookup_pc,
  output logic        taken,
  output logic [63:0] target,
  input  logic        upd,
  input  logic [63:0] upd_pc,
  input  logic [63:0] upd_target,
  input  logic        upd_taken
);
  localparam int IDX = $clog2(ENTRIES);
  btb_entry_t mem [ENTRIES];
  btb_entry_t rd, ur;
  logic [IDX-1:0] li, ui;
  logic hit, u_hit;
  always_comb begin
    li = lookup_pc[3 +: IDX];
    ui = upd_pc[3 +: IDX];
    rd = mem[li];
    ur = mem[ui];
    hit = rd.valid && rd.tag == lookup_pc >> (3 + IDX);
    u_hit = ur.valid && ur.tag == upd_pc >> (3 + IDX);
    taken = hit && rd.ctr[1];
    target = rd.target;
  end
  // lookup reads the array directly, so a same-cycle update is seen only next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
    end else if (upd && u_hit) begin
      mem[ui] <= '{valid: 1'b1, tag: ur.tag, target: upd_taken ? upd_target : ur.target,
                   ctr: ctr_next(ur.ctr, upd_taken)};
    end else if (upd && upd_taken) begin
      mem[ui] <= '{valid: 1'b1, tag: upd_pc >> (3 + IDX), target: upd_target, ctr: CTR_WEAK_T};
    end
  end
endmodule

// File: rtl/fetch.sv
// fetch: PC generation, imem requests, BTB prediction, instruction buffer and decode-facing output register
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int BTB_ENTRIES = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [63:0] redirect_pc_in,
  input  logic        btb_update_in,
  input  logic [63:0] btb_update_pc_in,
  input  logic [63:0] btb_update_target_in,
  input  logic        btb_update_taken_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [63:0] imem_addr_out,
  input  logic        imem_resp_valid_in,
  input  logic [63:0] imem_resp_data_in,
  output logic        valid_out,
  output logic        bubble_out,
  output logic [63:0] pc_out,
  output logic [63:0] instr_out,
  output logic        branch_predicted_taken_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [63:0] fetch_pc, pend_pc, btb_target;
  logic pend_pred, outstanding, drop, btb_taken, req_fire, push, pop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  fetch_entry_t fifo [FIFO_DEPTH];
  fetch_entry_t head;

  fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .lookup_pc (fetch_pc),
    .taken     (btb_taken),
    .target    (btb_target),
    .upd       (btb_update_in),
    .upd_pc    (btb_update_pc_in),
    .upd_target(btb_update_target_in),
    .upd_taken (btb_update_taken_in)
  );

  // a new request reserves a buffer slot, so the in-flight one counts as occupied
  always_comb begin
    pop = !stall_in && count != '0;
    imem_req_valid_out = rst_n && !flush_in && (!outstanding || imem_resp_valid_in) &&
      (count - (PW+1)'(pop) + (PW+1)'(outstanding) < (PW+1)'(FIFO_DEPTH));
    imem_addr_out = fetch_pc;
    req_fire = imem_req_valid_out && imem_req_ready_in;
    push = imem_resp_valid_in && outstanding && !drop && !flush_in;
    head = fifo[rd_ptr];
    bubble_out = !valid_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_VECTOR;
      outstanding <= 1'b0;
      drop <= 1'b0;
      pend_pc <= '0;
      pend_pred <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      valid_out <= 1'b0;
      pc_out <= '0;
      instr_out <= NOP_INSTR;
      branch_predicted_taken_out <= 1'b0;
    end else if (flush_in) begin
      fetch_pc <= redirect_pc_in & ~64'h7;
      outstanding <= outstanding && !imem_resp_valid_in;
      drop <= outstanding && !imem_resp_valid_in;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      branch_predicted_taken_out <= 1'b0;
    end else begin
      if (imem_resp_valid_in && outstanding) begin
        outstanding <= 1'b0;
        drop <= 1'b0;
      end
      if (req_fire) begin
        outstanding <= 1'b1;
        pend_pc <= fetch_pc;
        pend_pred <= btb_taken;
        fetch_pc <= btb_taken ? btb_target & ~64'h7 : fetch_pc + 64'd8;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (!stall_in) begin
        valid_out <= pop;
        pc_out <= pop ? head.pc : pc_out;
        instr_out <= pop ? head.instr : NOP_INSTR;
        branch_predicted_taken_out <= pop && head.pred;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: pend_pc, instr: imem_resp_data_in, pred: pend_pred};
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: self-checking bench for fetch with a behavioural imem and sequential-PC reference model
module tb_fetch;
  import fetch_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 1, stall_in = 0, flush_in = 0, btb_update_in = 0, btb_update_taken_in = 0;
  logic imem_req_ready_in = 0, imem_resp_valid_in = 0;
  logic [63:0] redirect_pc_in = '0, btb_update_pc_in = '0, btb_update_target_in = '0, imem_resp_data_in = '0;
  logic imem_req_valid_out, valid_out, bubble_out, branch_predicted_taken_out;
  logic [63:0] imem_addr_out, pc_out, instr_out;
  int n_chk = 0, n_fail = 0;
  logic pend = 0, stale = 0, rdy_rand = 0, lat_rand = 0;
  int lat_fix = 0, pend_dly = 0;
  logic [63:0] pend_addr = '0;

  always #5 clk = ~clk;

  fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in), .redirect_pc_in(redirect_pc_in),
    .btb_update_in(btb_update_in), .btb_update_pc_in(btb_update_pc_in),
    .btb_update_target_in(btb_update_target_in), .btb_update_taken_in(btb_update_taken_in),
    .imem_req_valid_out(imem_req_valid_out), .imem_req_ready_in(imem_req_ready_in),
    .imem_addr_out(imem_addr_out), .imem_resp_valid_in(imem_resp_valid_in),
    .imem_resp_data_in(imem_resp_data_in), .valid_out(valid_out), .bubble_out(bubble_out),
    .pc_out(pc_out), .instr_out(instr_out), .branch_predicted_taken_out(branch_predicted_taken_out)
  );

  function automatic logic [63:0] instr_of(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  // one clock: drive inputs and the imem response, record acceptance, advance past the edge
  task automatic step(input logic st, input logic fl, input logic [63:0] rd);
    logic acc;
    logic [63:0] a;
    stall_in = st;
    flush_in = fl;
    redirect_pc_in = rd;
    imem_resp_valid_in = stale || (pend && pend_dly == 0);
    imem_resp_data_in = stale ? 64'hDEAD_BEEF_DEAD_BEEF : instr_of(pend_addr);
    imem_req_ready_in = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    acc = imem_req_valid_out && imem_req_ready_in;
    a = imem_addr_out;
    n_chk++;
    if (acc && pend && !imem_resp_valid_in) begin
      n_fail++;
      $display("FAIL req_overlap: request %h issued while %h outstanding", a, pend_addr);
    end
    @(posedge clk);
    #1;
    if (imem_resp_valid_in) begin
      pend = 0;
      stale = 0;
    end else if (pend) pend_dly--;
    if (acc) begin
      pend = 1;
      pend_addr = a;
      pend_dly = lat_rand ? int'($urandom_range(0, 2)) : lat_fix;
    end
  endtask

  task automatic next_valid(output logic ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(0, 0, '0);
      ok = valid_out;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    stall_in = 0;
    flush_in = 0;
    btb_update_in = 0;
    imem_resp_valid_in = 0;
    imem_req_ready_in = 0;
    pend = 0;
    stale = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 0;
    #1;
    n_chk++;
    if ({valid_out, bubble_out, pc_out, instr_out, branch_predicted_taken_out, imem_req_valid_out} !==
        {1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_in: v=%b b=%b pc=%h ins=%h p=%b req=%b", valid_out, bubble_out, pc_out,
               instr_out, branch_predicted_taken_out, imem_req_valid_out);
    end
    do_reset();
    #1;
    n_chk++;
    if ({valid_out, bubble_out, pc_out, instr_out, imem_req_valid_out, imem_addr_out} !==
        {1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_release: v=%b b=%b pc=%h ins=%h req=%b addr=%h expected req=1 addr=0",
               valid_out, bubble_out, pc_out, instr_out, imem_req_valid_out, imem_addr_out);
    end
  endtask

  task automatic test_stream();
    logic [63:0] exp = 64'h0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, '0);
      n_chk++;
      if (valid_out !== (i >= 3)) begin
        n_fail++;
        $display("FAIL stream_valid: cycle %0d valid=%b expected %b", i, valid_out, i >= 3);
      end
      if (valid_out) begin
        n_chk++;
        if ({pc_out, instr_out, branch_predicted_taken_out, bubble_out} !== {exp, instr_of(exp), 2'b00}) begin
          n_fail++;
          $display("FAIL stream_data: pc=%h ins=%h p=%b b=%b expected pc=%h ins=%h", pc_out, instr_out,
                   branch_predicted_taken_out, bubble_out, exp, instr_of(exp));
        end
        exp += 64'd8;
      end
    end
  endtask

  task automatic test_stall();
    logic [129:0] held;
    logic [63:0] hp;
    held = {valid_out, pc_out, instr_out, branch_predicted_taken_out};
    hp = pc_out;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, '0);
      n_chk++;
      if ({valid_out, pc_out, instr_out, branch_predicted_taken_out} !== held) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d pc=%h v=%b expected held pc=%h", i, pc_out, valid_out, hp);
      end
    end
    n_chk++;
    if ({imem_req_valid_out, imem_addr_out} !== {1'b0, hp + 64'd8 * (DEPTH + 1)}) begin
      n_fail++;
      $display("FAIL stall_fill: req=%b next_addr=%h expected req=0 next_addr=%h", imem_req_valid_out,
               imem_addr_out, hp + 64'd8 * (DEPTH + 1));
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, '0);
      n_chk++;
      if ({valid_out, pc_out} !== {1'b1, hp + 64'd8 * i}) begin
        n_fail++;
        $display("FAIL stall_resume: step %0d v=%b pc=%h expected pc=%h", i, valid_out, pc_out, hp + 64'd8 * i);
      end
    end
  endtask

  task automatic test_flush();
    logic ok = 0;
    lat_fix = 2;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0, 0, '0);
      ok = pend && pend_dly > 0;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flush_setup: no slow request outstanding within bound");
    end
    step(0, 1, 64'h1004);
    lat_fix = 0;
    n_chk++;
    if ({valid_out, bubble_out, instr_out} !== {1'b0, 1'b1, NOP_INSTR}) begin
      n_fail++;
      $display("FAIL flush_clear: v=%b b=%b ins=%h expected invalid NOP", valid_out, bubble_out, instr_out);
    end
    next_valid(ok);
    n_chk++;
    if ({ok, pc_out, instr_out} !== {1'b1, 64'h1000, instr_of(64'h1000)}) begin
      n_fail++;
      $display("FAIL flush_target: ok=%b pc=%h ins=%h expected pc=1000 ins=%h", ok, pc_out, instr_out,
               instr_of(64'h1000));
    end
    next_valid(ok);
    n_chk++;
    if ({ok, pc_out} !== {1'b1, 64'h1008}) begin
      n_fail++;
      $display("FAIL flush_next: ok=%b pc=%h expected 1008", ok, pc_out);
    end
  endtask

  // BTB counter modelled as a saturating integer 0..3 with prediction at >=2
  task automatic test_btb();
    logic [8:0] seq = 9'b001110010;
    logic have = 0, ok, tk, ep;
    int ctr = 0;
    logic [63:0] tgt = '0, t, p;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tk = seq[k];
      t = 64'h200 + 64'(k) * 64'h100;
      btb_update_in = 1;
      btb_update_pc_in = 64'h40;
      btb_update_target_in = t;
      btb_update_taken_in = tk;
      step(1, 0, '0);
      btb_update_in = 0;
      if (!have) begin
        if (tk) begin
          have = 1;
          ctr = 2;
          tgt = t;
        end
      end else begin
        ctr = tk ? (ctr < 3 ? ctr + 1 : 3) : (ctr > 0 ? ctr - 1 : 0);
        if (tk) tgt = t;
      end
      for (int j = 0; j < 2; j++) begin
        p = j ? 64'h440 : 64'h40;
        ep = (j == 0) && have && ctr >= 2;
        step(0, 1, p);
        next_valid(ok);
        n_chk++;
        if ({ok, pc_out, branch_predicted_taken_out} !== {1'b1, p, ep}) begin
          n_fail++;
          $display("FAIL btb_pred: iter %0d ok=%b pc=%h pred=%b expected pc=%h pred=%b", k, ok, pc_out,
                   branch_predicted_taken_out, p, ep);
        end
        next_valid(ok);
        n_chk++;
        if ({ok, pc_out} !== {1'b1, ep ? tgt : p + 64'd8}) begin
          n_fail++;
          $display("FAIL btb_next: iter %0d ok=%b pc=%h expected %h", k, ok, pc_out, ep ? tgt : p + 64'd8);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ok = 0;
    lat_fix = 2;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(0, 0, '0);
      ok = pend && pend_dly > 0;
    end
    #2;
    rst_n = 0;
    #1;
    n_chk++;
    if (!ok || {valid_out, bubble_out, pc_out, instr_out, branch_predicted_taken_out, imem_req_valid_out} !==
        {1'b0, 1'b1, 64'h0, NOP_INSTR, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid: setup=%b v=%b b=%b pc=%h ins=%h p=%b req=%b", ok, valid_out, bubble_out,
               pc_out, instr_out, branch_predicted_taken_out, imem_req_valid_out);
    end
    stale = pend;
    pend = 0;
    lat_fix = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    next_valid(ok);
    n_chk++;
    if ({ok, pc_out, instr_out} !== {1'b1, 64'h0, instr_of(64'h0)}) begin
      n_fail++;
      $display("FAIL reset_mid_first: ok=%b pc=%h ins=%h expected pc=0 ins=%h", ok, pc_out, instr_out, instr_of(0));
    end
    next_valid(ok);
    n_chk++;
    if ({ok, pc_out} !== {1'b1, 64'h8}) begin
      n_fail++;
      $display("FAIL reset_mid_second: ok=%b pc=%h expected 8", ok, pc_out);
    end
  endtask

  task automatic test_random();
    logic st, fl;
    logic [63:0] rd, exp = 64'h0;
    logic [129:0] prev;
    int nout = 0;
    do_reset();
    rdy_rand = 1;
    lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      st = $urandom_range(0, 3) == 0;
      fl = ($urandom_range(0, 24) == 0) || i == 150;
      rd = (i == 150) ? 64'hFFFF_FFFF_FFFF_FFF3 : {$urandom, $urandom};
      prev = {valid_out, pc_out, instr_out, branch_predicted_taken_out};
      step(st, fl, rd);
      n_chk++;
      if (fl) begin
        if (valid_out !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_flush: cycle %0d valid=%b expected 0", i, valid_out);
        end
        exp = rd & ~64'h7;
      end else if (st) begin
        if ({valid_out, pc_out, instr_out, branch_predicted_taken_out} !== prev) begin
          n_fail++;
          $display("FAIL rand_hold: cycle %0d pc=%h v=%b changed from pc=%h", i, pc_out, valid_out, prev[128:65]);
        end
      end else if (valid_out) begin
        if ({pc_out, instr_out, branch_predicted_taken_out} !== {exp, instr_of(exp), 1'b0}) begin
          n_fail++;
          $display("FAIL rand_data: cycle %0d pc=%h ins=%h p=%b expected pc=%h ins=%h", i, pc_out, instr_out,
                   branch_predicted_taken_out, exp, instr_of(exp));
        end
        exp += 64'd8;
        nout++;
      end else if ({instr_out, branch_predicted_taken_out} !== {NOP_INSTR, 1'b0}) begin
        n_fail++;
        $display("FAIL rand_bubble: cycle %0d ins=%h p=%b expected NOP", i, instr_out, branch_predicted_taken_out);
      end
      n_chk++;
      if (bubble_out !== !valid_out) begin
        n_fail++;
        $display("FAIL rand_bubble_flag: cycle %0d bubble=%b valid=%b", i, bubble_out, valid_out);
      end
    end
    n_chk++;
    if (nout < 50) begin
      n_fail++;
      $display("FAIL rand_progress: %0d instructions delivered, required at least 50", nout);
    end
    rdy_rand = 0;
    lat_rand = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_btb();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
